// File: rtl/datamemory_arbiter.sv
// datamemory_arbiter: two-port valid/ready arbiter for the single-port data memory;
// define DMEM_ARB_RR_EN for round-robin ties, otherwise port 0 has fixed priority.
module datamemory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic port, op, grant1, accept;
  logic [DATA_W-1:0] hold0, hold1;
`ifdef DMEM_ARB_RR_EN
  logic pref1;
  assign grant1 = req1_valid && (!req0_valid || pref1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pref1 <= 1'b0;
    else if (accept) pref1 <= !grant1;
`else
  assign grant1 = req1_valid && !req0_valid;
`endif
  assign req0_ready = !rst && state == IDLE && req0_valid && !grant1;
  assign req1_ready = !rst && state == IDLE && grant1;
  assign accept = req0_ready || req1_ready;
  // read data is only valid from the memory during RESP, so it bypasses the hold register then
  assign rsp0_rdata = (rsp0_valid && !op) ? mem_rdata : hold0;
  assign rsp1_rdata = (rsp1_valid && !op) ? mem_rdata : hold1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_din <= '0;
      mem_rw <= 1'b0;
      port <= 1'b0;
      op <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          mem_addr <= grant1 ? req1_addr : req0_addr;
          mem_din <= grant1 ? req1_wdata : req0_wdata;
          mem_rw <= grant1 ? req1_rw : req0_rw;
          op <= grant1 ? req1_rw : req0_rw;
          port <= grant1;
          state <= ACCESS;
        end
        ACCESS: begin
          mem_rw <= 1'b0;
          rsp0_valid <= !port;
          rsp1_valid <= port;
          state <= RESP;
        end
        default: begin
          if (rsp0_valid && !op) hold0 <= mem_rdata;
          if (rsp1_valid && !op) hold1 <= mem_rdata;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_datamemory_arbiter.sv
// tb_datamemory_arbiter: directed scenarios plus randomized traffic against a
// cycle-count/queue reference model; includes a synchronous data memory model.
module tb_datamemory_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req0_rw = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic req1_valid = 1'b0, req1_rw = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic req0_ready, rsp0_valid, req1_ready, rsp1_valid, mem_rw;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata, mem_din, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [1024];
  bit wr [1024];
  logic [DW-1:0] ref_mem [1024];
  int checks = 0;
  int errors = 0;
  int last_g = 1;

  always #5 clk = ~clk;

  datamemory_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] preset(input logic [AW-1:0] a);
    return a == 0 ? 32'd2001 : a == 1 ? 32'd4001 : a == 2 ? 32'd5001 : a == 5 ? 32'd6001 : 32'(a) * 3 + 7;
  endfunction

  always @(posedge clk) begin
    if (mem_rw) begin
      mem[mem_addr] <= mem_din;
      wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= wr[mem_addr] ? mem[mem_addr] : preset(mem_addr);
  end

  task automatic set0(input logic v, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_rw = rw; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_rw = rw; req1_addr = a; req1_wdata = d;
  endtask

  task automatic test_reset;
    @(negedge clk);
    set0(1, 1, 5, 123); set1(1, 0, 2, 0);
    #1;
    checks++;
    if ({req0_ready, req1_ready, mem_rw, rsp0_valid, rsp1_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {req0_ready, req1_ready, mem_rw, rsp0_valid, rsp1_valid});
    end
    checks++;
    if (mem_addr !== 0 || mem_din !== 0 || rsp0_rdata !== 0 || rsp1_rdata !== 0) begin
      errors++; $display("FAIL reset_data: addr %h din %h r0 %h r1 %h want all 0", mem_addr, mem_din, rsp0_rdata, rsp1_rdata);
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    last_g = 1;
  endtask

  task automatic test_read0;
    @(negedge clk); set0(1, 0, 1, 0); #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL read0_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk); set0(0, 0, 0, 0); #1;
    checks++;
    if (mem_rw !== 1'b0 || mem_addr !== 10'd1 || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL read0_access: rw %b addr %0d rsp %b want 0 1 0", mem_rw, mem_addr, rsp0_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== ref_mem[1]) begin
      errors++; $display("FAIL read0_rsp: v0 %b v1 %b data %0d want 1 0 %0d", rsp0_valid, rsp1_valid, rsp0_rdata, ref_mem[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp0_rdata !== ref_mem[1]) begin
      errors++; $display("FAIL read0_hold: v0 %b data %0d want 0 %0d", rsp0_valid, rsp0_rdata, ref_mem[1]);
    end
    last_g = 0;
  endtask

  task automatic test_write1;
    @(negedge clk); set1(1, 1, 3, 32'd7777); #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL write1_ready: got %b%b want 01", req0_ready, req1_ready);
    end
    @(negedge clk); set1(0, 0, 0, 0); #1;
    checks++;
    if (mem_rw !== 1'b1 || mem_addr !== 10'd3 || mem_din !== 32'd7777 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL write1_access: rw %b addr %0d din %0d rsp %b want 1 3 7777 0", mem_rw, mem_addr, mem_din, rsp1_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_rw !== 1'b0 || rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_rdata !== 0) begin
      errors++; $display("FAIL write1_ack: rw %b v1 %b v0 %b data %0d want 0 1 0 0", mem_rw, rsp1_valid, rsp0_valid, rsp1_rdata);
    end
    ref_mem[3] = 32'd7777;
    last_g = 1;
    @(negedge clk); set1(1, 0, 3, 0); #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL raw_ready: got %b want 1", req1_ready);
    end
    @(negedge clk); set1(0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'd7777) begin
      errors++; $display("FAIL raw_data: v1 %b data %0d want 1 7777", rsp1_valid, rsp1_rdata);
    end
  endtask

  task automatic test_tie;
    int g;
`ifdef DMEM_ARB_RR_EN
    g = 1 - last_g;
`else
    g = 0;
`endif
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin set0(1, 0, 0, 0); set1(1, 0, 2, 0); end
      #1;
      checks++;
      if (req0_ready !== 1'((k % 3 == 0) && g == 0) || req1_ready !== 1'((k % 3 == 0) && g == 1)) begin
        errors++; $display("FAIL tie_grant k=%0d: got %b%b want port %0d on k%%3==0", k, req0_ready, req1_ready, g);
      end
      if (k % 3 == 2) begin
        checks++;
        if (rsp0_valid !== 1'(g == 0) || rsp1_valid !== 1'(g == 1) || (g == 0 ? rsp0_rdata : rsp1_rdata) !== (g == 0 ? ref_mem[0] : ref_mem[2])) begin
          errors++; $display("FAIL tie_rsp k=%0d: v %b%b d0 %0d d1 %0d want port %0d", k, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, g);
        end
        last_g = g;
`ifdef DMEM_ARB_RR_EN
        g = 1 - g;
`endif
      end
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk); set0(1, 1, 5, 32'd12345); #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_ready: got %b want 1", req0_ready);
    end
    @(posedge clk); #1; set0(0, 0, 0, 0);
    checks++;
    if (mem_rw !== 1'b1) begin
      errors++; $display("FAIL rmid_access: rw %b want 1", mem_rw);
    end
    rst = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready, mem_rw, rsp0_valid, rsp1_valid} !== 5'b0 || mem_addr !== 0 || mem_din !== 0 || rsp0_rdata !== 0 || rsp1_rdata !== 0) begin
      errors++; $display("FAIL rmid_reset: ctl %b addr %h din %h r0 %h r1 %h want all 0", {req0_ready, req1_ready, mem_rw, rsp0_valid, rsp1_valid}, mem_addr, mem_din, rsp0_rdata, rsp1_rdata);
    end
    @(negedge clk); rst = 1'b0;
    last_g = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mem_rw !== 1'b0) begin
        errors++; $display("FAIL rmid_quiet k=%0d: v %b%b rw %b want 000", k, rsp0_valid, rsp1_valid, mem_rw);
      end
    end
    @(negedge clk); set0(1, 0, 5, 0);
    @(negedge clk); set0(0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== ref_mem[5]) begin
      errors++; $display("FAIL rmid_nocommit: v0 %b data %0d want 1 %0d", rsp0_valid, rsp0_rdata, ref_mem[5]);
    end
    last_g = 0;
  endtask

  task automatic test_wait;
    @(negedge clk); set0(1, 0, 1, 0); #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL wait_ready0: got %b want 1", req0_ready);
    end
    @(negedge clk); set0(0, 0, 0, 0); set1(1, 0, 2, 0); #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++; $display("FAIL wait_access: ready1 %b want 0", req1_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_rdata !== ref_mem[1]) begin
      errors++; $display("FAIL wait_resp: ready1 %b v0 %b d0 %0d want 0 1 %0d", req1_ready, rsp0_valid, rsp0_rdata, ref_mem[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL wait_grant: got %b%b want 01", req0_ready, req1_ready);
    end
    @(negedge clk); set1(0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_rdata !== ref_mem[2]) begin
      errors++; $display("FAIL wait_rsp1: v1 %b d1 %0d want 1 %0d", rsp1_valid, rsp1_rdata, ref_mem[2]);
    end
    last_g = 1;
  endtask

  task automatic test_cancel;
    @(negedge clk); set1(1, 0, 0, 0);
    @(negedge clk); set1(1, 1, 6, 32'd999); set0(1, 1, 7, 32'd4242); #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL cancel_busy: got %b%b want 00", req0_ready, req1_ready);
    end
    @(negedge clk); set0(0, 0, 0, 0); #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp1_valid !== 1'b1 || rsp1_rdata !== ref_mem[0]) begin
      errors++; $display("FAIL cancel_resp: rdy %b%b v1 %b d1 %0d want 00 1 %0d", req0_ready, req1_ready, rsp1_valid, rsp1_rdata, ref_mem[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL cancel_grant: got %b%b want 01", req0_ready, req1_ready);
    end
    @(negedge clk); set1(0, 0, 0, 0); #1;
    checks++;
    if (mem_rw !== 1'b1 || mem_addr !== 10'd6 || mem_din !== 32'd999) begin
      errors++; $display("FAIL cancel_access: rw %b addr %0d din %0d want 1 6 999", mem_rw, mem_addr, mem_din);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'(k == 0) || mem_rw !== 1'b0) begin
        errors++; $display("FAIL cancel_after k=%0d: v %b%b rw %b want 0%b0", k, rsp0_valid, rsp1_valid, mem_rw, 1'(k == 0));
      end
    end
    ref_mem[6] = 32'd999;
    last_g = 1;
    @(negedge clk); set0(1, 0, 7, 0);
    @(negedge clk); set0(0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== ref_mem[7]) begin
      errors++; $display("FAIL cancel_nowrite: v0 %b d0 %0d want 1 %0d", rsp0_valid, rsp0_rdata, ref_mem[7]);
    end
    last_g = 0;
  endtask

  task automatic test_random;
    logic pv [2];
    logic prw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] rsp_data;
    logic rsp_rd;
    int free_at, rsp_at, wr_at, rsp_port, g;
    pv = '{1'b0, 1'b0}; prw = '{1'b0, 1'b0}; pa = '{10'd0, 10'd0}; pd = '{32'd0, 32'd0};
    exp_rd = '{32'd0, 32'd0}; rsp_data = '0; rsp_rd = 1'b0;
    free_at = 0; rsp_at = -1; wr_at = -1; rsp_port = 0;
    @(negedge clk); rst = 1'b1; set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    last_g = 1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (pv[p] && $urandom_range(15) == 0) pv[p] = 1'b0;
        else if (!pv[p] && $urandom_range(1) == 1) begin
          pv[p] = 1'b1;
          prw[p] = 1'($urandom_range(1));
          pa[p] = $urandom_range(3) == 0 ? AW'($urandom) : AW'($urandom_range(7));
          pd[p] = $urandom;
        end
      end
      set0(pv[0], prw[0], pa[0], pd[0]);
      set1(pv[1], prw[1], pa[1], pd[1]);
      #1;
      if (k == rsp_at && rsp_rd) exp_rd[rsp_port] = rsp_data;
      checks++;
      if (mem_rw !== 1'(k == wr_at)) begin
        errors++; $display("FAIL rand_rw k=%0d: got %b want %b", k, mem_rw, 1'(k == wr_at));
      end
      checks++;
      if (rsp0_valid !== 1'(k == rsp_at && rsp_port == 0) || rsp1_valid !== 1'(k == rsp_at && rsp_port == 1)) begin
        errors++; $display("FAIL rand_rspv k=%0d: got %b%b want %b%b", k, rsp0_valid, rsp1_valid, 1'(k == rsp_at && rsp_port == 0), 1'(k == rsp_at && rsp_port == 1));
      end
      checks++;
      if (rsp0_rdata !== exp_rd[0] || rsp1_rdata !== exp_rd[1]) begin
        errors++; $display("FAIL rand_rdata k=%0d: got %h %h want %h %h", k, rsp0_rdata, rsp1_rdata, exp_rd[0], exp_rd[1]);
      end
      g = -1;
      if (k >= free_at) begin
`ifdef DMEM_ARB_RR_EN
        if (pv[0] && pv[1]) g = 1 - last_g;
`else
        if (pv[0] && pv[1]) g = 0;
`endif
        else if (pv[0]) g = 0;
        else if (pv[1]) g = 1;
      end
      checks++;
      if (req0_ready !== 1'(g == 0) || req1_ready !== 1'(g == 1)) begin
        errors++; $display("FAIL rand_ready k=%0d: got %b%b want grant %0d", k, req0_ready, req1_ready, g);
      end
      if (g >= 0) begin
        free_at = k + 3;
        rsp_at = k + 2;
        rsp_port = g;
        rsp_rd = !prw[g];
        wr_at = prw[g] ? k + 1 : -1;
        if (prw[g]) ref_mem[pa[g]] = pd[g];
        else rsp_data = ref_mem[pa[g]];
        last_g = g;
        pv[g] = 1'b0;
      end
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = preset(AW'(i));
    test_reset;
    test_read0;
    test_write1;
    test_tie;
    test_reset_mid;
    test_wait;
    test_cancel;
    test_random;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/datamemory_arbiter.md
# datamemory_arbiter

Two-port arbiter that shares the single-port data memory (`datamemory`: 10-bit word address, 32-bit data, `rw`=1 write / 0 read, synchronous on `posedge clk`) between two requesters, e.g. the core's load/store stage (port 0) and a debug/DMA master (port 1). Each port has a valid/ready request handshake and a one-cycle response pulse. The block registers the selected request into the memory's `addr`/`din`/`rw` inputs and returns `S_datamemory` to the winning port.

## Interface
- `ADDR_W`, 10, word address width (matches memory `addr`)
- `DATA_W`, 32, data width (matches memory `din` / `S_datamemory`)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  port 0 request present
- `req0_rw`  in  1  port 0: 1 = write, 0 = read
- `req0_addr`  in  ADDR_W  port 0 word address
- `req0_wdata`  in  DATA_W  port 0 write data
- `req0_ready`  out  1  port 0 request accepted this cycle
- `rsp0_valid`  out  1  port 0 response pulse (read data or write ack)
- `rsp0_rdata`  out  DATA_W  port 0 read data
- `req1_valid`, `req1_rw`, `req1_addr`, `req1_wdata`, `req1_ready`, `rsp1_valid`, `rsp1_rdata`: same as port 0, for port 1
- `mem_addr`  out  ADDR_W  to memory `addr`, registered
- `mem_din`  out  DATA_W  to memory `din`, registered
- `mem_rw`  out  1  to memory `rw`, registered; 1 only during a write ACCESS cycle
- `mem_rdata`  in  DATA_W  from memory `S_datamemory`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `reqN_ready` is combinational and asserted only for the granted port; at most one ready is high.
  - Grant: a single valid port wins. If both are valid, the tie rule applies (see Configuration).
  - On accept (`valid && ready`): load `mem_addr`, `mem_din`, and `mem_rw` (= `req_rw`); latch the port id and the op; go to ACCESS.
- ACCESS: the memory samples the registered inputs at the end of this cycle. A write commits; a read updates `S_datamemory`. `mem_rw` clears to 0 on exit. Go to RESP.
- RESP:
  - Assert `rspN_valid` for the latched port for exactly one cycle.
  - Read: `rspN_rdata` = `mem_rdata`, held until that port's next read response.
  - Write: `rspN_rdata` is unchanged.
  - Go to IDLE.
- `mem_rw` is never 1 outside ACCESS. This prevents spurious writes while idle.
- Requesters hold `valid`, `rw`, `addr`, and `wdata` stable until ready. Dropping `valid` before ready is legal and cancels the request.
- No response backpressure: the requester must accept `rsp_valid`.
- Addresses are used modulo 2^ADDR_W. There is no range check.

## Timing
- Reset values:
  - State: IDLE.
  - `mem_addr`, `mem_din`, `mem_rw`: 0.
  - `req0_ready`, `req1_ready`: 0 while `rst` is high.
  - `rsp0_valid`, `rsp1_valid`: 0.
  - `rsp0_rdata`, `rsp1_rdata`: 0.
  - Round-robin pointer: port 0 preferred.
- Accept in cycle T gives ACCESS in T+1 and `rsp_valid` in T+2. Earliest next accept is T+3. Peak rate is one access per 3 cycles.
- Requests asserted during ACCESS or RESP wait; ready stays low for both ports.
- Reset mid-operation: `mem_rw` drops immediately (asynchronous). A write whose ACCESS edge has not yet occurred does not commit. A pending response is discarded. The FSM returns to IDLE.
- Read-after-write to the same address from either port returns the new data, because the accesses are serialized.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration. On a tie, grant the port not granted most recently.
  - The pointer updates only on accept.
- Not defined:
  - Fixed priority: port 0 always wins a tie. Port 1 can starve.
  - The pointer register is not built.

## Test plan
- Port 0 reads address 1 (memory preset M[1]=4001) → `req0_ready` high in T, `mem_rw`=0, `rsp0_valid` pulse in T+2 with `rsp0_rdata`=4001, `rsp1_valid` stays 0.
- Port 1 writes 32'd7777 to address 3, then reads address 3 → write ack `rsp1_valid` with `rsp1_rdata` unchanged; `mem_rw`=1 in the ACCESS cycle only; read returns 7777.
- Both ports hold read requests continuously (port 0 to address 0 = 2001, port 1 to address 2 = 5001):
  - With `DMEM_ARB_RR_EN`: grants alternate 0,1,0,1 every 3 cycles and the responses carry the correct data.
  - Without it: only port 0 is granted.
- Port 0 write to address 5 with `rst` pulsed during its IDLE→ACCESS window, before the ACCESS edge → `mem_rw` goes 0 asynchronously, no response, and a later read of address 5 returns the old value. All outputs show reset values.
- Port 1 raises valid during port 0's ACCESS cycle → `req1_ready` stays 0 until IDLE, then is accepted exactly 3 cycles after port 0's accept.
- Port 0 drops `req0_valid` in the same cycle that port 1's request is granted → no port 0 access, and the port 1 access completes normally.
